// File: rtl/mipi_csi2_pkg.sv
// Shared definitions for the CSI-2 packet layer.
//   - data type codes for the short packets and the supported RAW formats
//   - parser state enum and data-type classification enum
//   - CRC-16 constants and a byte-wise CRC update helper
//   - group size (bytes per unpack group) as a function of data type
package mipi_csi2_pkg;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_LS    = 6'h02;
    localparam logic [5:0] DT_LE    = 6'h03;
    localparam logic [5:0] DT_RAW8  = 6'h2A;
    localparam logic [5:0] DT_RAW10 = 6'h2B;
    localparam logic [5:0] DT_RAW12 = 6'h2C;

    // x^16+x^12+x^5+1 in bit-reversed form, because bytes are shifted in LSB first
    localparam logic [15:0] CRC_POLY = 16'h8408;
    localparam logic [15:0] CRC_SEED = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        CRC,
        DRAIN
    } state_t;

    typedef enum logic [2:0] {
        DTC_FS,
        DTC_FE,
        DTC_SHORT,
        DTC_RAW,
        DTC_BAD
    } dt_class_t;

    function automatic logic [2:0] group_size(input logic [5:0] dt);
        case (dt)
            DT_RAW10: return 3'd5;
            DT_RAW12: return 3'd3;
            default:  return 3'd1;
        endcase
    endfunction

    function automatic dt_class_t classify_dt(input logic [5:0] dt);
        case (dt)
            DT_FS:                       return DTC_FS;
            DT_FE:                       return DTC_FE;
            DT_LS, DT_LE:                return DTC_SHORT;
            DT_RAW8, DT_RAW10, DT_RAW12: return DTC_RAW;
            default:                     return (dt < 6'h10) ? DTC_SHORT : DTC_BAD;
        endcase
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ data[i])
                c = (c >> 1) ^ CRC_POLY;
            else
                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/mipi_csi2_crc16.sv
// Registered CSI-2 payload CRC-16 accumulator.
//   clk, reset : clock and synchronous active-high reset (reset loads the seed)
//   init       : reload the seed
//   en         : fold din into the running CRC
//   din        : payload byte
//   crc        : current CRC state
module mipi_csi2_crc16
    import mipi_csi2_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);

    always_ff @(posedge clk) begin
        if (reset || init)
            crc <= CRC_SEED;
        else if (en)
            crc <= crc16_byte(crc, din);
    end

endmodule

// File: rtl/mipi_csi2_unpack.sv
// CSI-2 packet layer: parses short/long packet headers from the PHY byte
// stream, unpacks RAW8/RAW10/RAW12 payloads into MSB-aligned pixels, checks
// payload CRC and word-count integrity, and drives pixel/line/frame strobes.
//   clk, reset            : byte clock, synchronous active-high reset
//   enable                : parser enable; low flushes the parser and outputs
//   phy_we, phy_dvo       : HS burst active, byte valid
//   phy_data              : received byte
//   vc_filter_en/vc_select: optional virtual channel filter
//   dato, dvo             : pixel and pixel valid
//   lvo, fvo              : line valid, frame valid
//   frame_count           : accepted frame-end count (wraps)
//   err_crc/trunc/wc/dtype: one-cycle error pulses
module mipi_csi2_unpack
    import mipi_csi2_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH     = 12,
    parameter int unsigned QUEUE_DEPTH     = 8,
    parameter int unsigned FRAME_CNT_WIDTH = 16
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       phy_we,
    input  logic                       phy_dvo,
    input  logic [7:0]                 phy_data,
    input  logic                       vc_filter_en,
    input  logic [1:0]                 vc_select,
    output logic [PIXEL_WIDTH-1:0]     dato,
    output logic                       dvo,
    output logic                       lvo,
    output logic                       fvo,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic                       err_crc,
    output logic                       err_trunc,
    output logic                       err_wc,
    output logic                       err_dtype
);

    localparam int unsigned QAW  = $clog2(QUEUE_DEPTH);
    localparam int unsigned PTRW = QAW + 1;

    state_t            state;
    logic [1:0]        hdr_idx;
    logic [1:0]        hdr_vc;
    logic [5:0]        hdr_dt;
    logic [15:0]       wc;
    logic [7:0]        grp [4];
    logic [2:0]        grp_cnt;
    logic [7:0]        crc_lo;
    logic              crc_idx;
    logic              pkt_open;
    logic              pkt_id;
    logic              cur_id;
    logic              fe_pend;

    logic [PIXEL_WIDTH-1:0] q_pix [QUEUE_DEPTH];
    logic                   q_id  [QUEUE_DEPTH];
    logic [PTRW-1:0]        wr_ptr;
    logic [PTRW-1:0]        rd_ptr;

    logic                   byte_ok;
    logic                   vc_ok;
    dt_class_t              dtc;
    logic [2:0]             gsize;
    logic                   grp_done;
    logic [2:0]             npx;
    logic [15:0]            raw16 [4];
    logic [PIXEL_WIDTH-1:0] px    [4];
    logic [QAW-1:0]         widx  [4];
    logic                   q_empty;
    logic                   head_id;
    logic                   pop;
    logic                   dvo_n;
    logic                   lvo_n;
    logic [15:0]            crc_val;
    logic                   crc_init;
    logic                   crc_en;

    assign byte_ok  = phy_we && phy_dvo;
    assign vc_ok    = !vc_filter_en || (hdr_vc == vc_select);
    assign dtc      = classify_dt(hdr_dt);
    assign q_empty  = (wr_ptr == rd_ptr);
    assign head_id  = q_id[rd_ptr[QAW-1:0]];
    assign crc_init = (state == HEADER);
    assign crc_en   = (state == PAYLOAD) && byte_ok;

    mipi_csi2_crc16 u_crc (
        .clk   (clk),
        .reset (reset),
        .init  (crc_init),
        .en    (crc_en),
        .din   (phy_data),
        .crc   (crc_val)
    );

    // Group assembly: the group-completing byte is taken straight from
    // phy_data so the whole group lands in the queue on its accept edge.
    always_comb begin
        gsize    = group_size(hdr_dt);
        grp_done = (state == PAYLOAD) && byte_ok && (grp_cnt == gsize - 3'd1);
        npx      = 3'd1;
        for (int unsigned i = 0; i < 4; i++)
            raw16[i] = '0;
        case (hdr_dt)
            DT_RAW10: begin
                npx = 3'd4;
                for (int unsigned i = 0; i < 4; i++)
                    raw16[i] = {grp[i], phy_data[2*i +: 2], 6'b0};
            end
            DT_RAW12: begin
                npx      = 3'd2;
                raw16[0] = {grp[0], phy_data[3:0], 4'b0};
                raw16[1] = {grp[1], phy_data[7:4], 4'b0};
            end
            default: raw16[0] = {phy_data, 8'b0};
        endcase
        for (int unsigned i = 0; i < 4; i++) begin
            px[i]   = raw16[i][15 -: PIXEL_WIDTH];
            widx[i] = wr_ptr[QAW-1:0] + QAW'(i);
        end
    end

    // Each queue entry carries the toggling id of its packet. When the head
    // belongs to a different packet than the line being shown, one pop is
    // skipped so lvo drops for a cycle between back-to-back lines.
    always_comb begin
        pop   = 1'b0;
        dvo_n = 1'b0;
        lvo_n = lvo;
        if (!q_empty) begin
            if (lvo && (head_id != cur_id)) begin
                lvo_n = 1'b0;
            end else begin
                pop   = 1'b1;
                dvo_n = 1'b1;
                lvo_n = 1'b1;
            end
        end else if (lvo && (!pkt_open || (pkt_id != cur_id))) begin
            lvo_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        err_crc   <= 1'b0;
        err_trunc <= 1'b0;
        err_wc    <= 1'b0;
        err_dtype <= 1'b0;
        if (reset) begin
            state       <= IDLE;
            hdr_idx     <= '0;
            hdr_vc      <= '0;
            hdr_dt      <= '0;
            wc          <= '0;
            grp_cnt     <= '0;
            crc_lo      <= '0;
            crc_idx     <= 1'b0;
            pkt_open    <= 1'b0;
            pkt_id      <= 1'b0;
            cur_id      <= 1'b0;
            fe_pend     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            dato        <= '0;
            dvo         <= 1'b0;
            lvo         <= 1'b0;
            fvo         <= 1'b0;
            frame_count <= '0;
        end else if (!enable) begin
            state    <= IDLE;
            pkt_open <= 1'b0;
            fe_pend  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            dato     <= '0;
            dvo      <= 1'b0;
            lvo      <= 1'b0;
            fvo      <= 1'b0;
        end else begin
            dvo <= dvo_n;
            lvo <= lvo_n;
            if (pop) begin
                dato   <= q_pix[rd_ptr[QAW-1:0]];
                cur_id <= head_id;
                rd_ptr <= rd_ptr + PTRW'(1);
            end

            if (grp_done) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (3'(i) < npx) begin
                        q_pix[widx[i]] <= px[i];
                        q_id[widx[i]]  <= pkt_id;
                    end
                end
                wr_ptr <= wr_ptr + PTRW'(npx);
            end

            // A frame end seen while pixels were still in flight closes the
            // frame once the last line has fully left.
            if (fe_pend && !lvo_n && q_empty) begin
                fvo     <= 1'b0;
                fe_pend <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (byte_ok) begin
                        hdr_vc  <= phy_data[7:6];
                        hdr_dt  <= phy_data[5:0];
                        hdr_idx <= 2'd1;
                        state   <= HEADER;
                    end
                end

                HEADER: begin
                    if (!phy_we) begin
                        err_trunc <= 1'b1;
                        state     <= IDLE;
                    end else if (phy_dvo) begin
                        hdr_idx <= hdr_idx + 2'd1;
                        case (hdr_idx)
                            2'd1: wc[7:0]  <= phy_data;
                            2'd2: wc[15:8] <= phy_data;
                            default: begin
                                state <= DRAIN;
                                if (vc_ok) begin
                                    case (dtc)
                                        DTC_FS: begin
                                            fvo     <= 1'b1;
                                            fe_pend <= 1'b0;
                                        end
                                        DTC_FE: begin
                                            frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
                                            if (!lvo_n && q_empty)
                                                fvo <= 1'b0;
                                            else
                                                fe_pend <= 1'b1;
                                        end
                                        DTC_RAW: begin
                                            grp_cnt  <= '0;
                                            crc_idx  <= 1'b0;
                                            pkt_id   <= ~pkt_id;
                                            pkt_open <= (wc != 16'd0);
                                            state    <= (wc == 16'd0) ? CRC : PAYLOAD;
                                        end
                                        DTC_BAD: err_dtype <= 1'b1;
                                        default: ;
                                    endcase
                                end
                            end
                        endcase
                    end
                end

                PAYLOAD: begin
                    if (!phy_we) begin
                        err_trunc <= 1'b1;
                        pkt_open  <= 1'b0;
                        state     <= IDLE;
                    end else if (phy_dvo) begin
                        wc <= wc - 16'd1;
                        if (grp_done) begin
                            grp_cnt <= '0;
                        end else begin
                            grp[grp_cnt[1:0]] <= phy_data;
                            grp_cnt           <= grp_cnt + 3'd1;
                        end
                        if (wc == 16'd1) begin
                            pkt_open <= 1'b0;
                            err_wc   <= !grp_done;
                            state    <= CRC;
                        end
                    end
                end

                CRC: begin
                    if (!phy_we) begin
                        err_trunc <= 1'b1;
                        state     <= IDLE;
                    end else if (phy_dvo) begin
                        if (!crc_idx) begin
                            crc_lo  <= phy_data;
                            crc_idx <= 1'b1;
                        end else begin
                            err_crc <= ({phy_data, crc_lo} != crc_val);
                            state   <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (!phy_we)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_csi2_unpack.sv
// Directed/randomized testbench for mipi_csi2_unpack with a behavioural
// packet/pixel/CRC reference model.
module tb_mipi_csi2_unpack;

    localparam int PW = 12;

    typedef logic [7:0]    bq_t[$];
    typedef logic [PW-1:0] pq_t[$];

    logic          clk = 1'b0;
    logic          reset, enable, phy_we, phy_dvo, vc_filter_en;
    logic [7:0]    phy_data;
    logic [1:0]    vc_select;
    logic [PW-1:0] dato;
    logic          dvo, lvo, fvo;
    logic [15:0]   frame_count;
    logic          err_crc, err_trunc, err_wc, err_dtype;

    always #5 clk = ~clk;

    mipi_csi2_unpack #(.PIXEL_WIDTH(PW), .QUEUE_DEPTH(8), .FRAME_CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .phy_we(phy_we), .phy_dvo(phy_dvo),
        .phy_data(phy_data), .vc_filter_en(vc_filter_en), .vc_select(vc_select),
        .dato(dato), .dvo(dvo), .lvo(lvo), .fvo(fvo), .frame_count(frame_count),
        .err_crc(err_crc), .err_trunc(err_trunc), .err_wc(err_wc), .err_dtype(err_dtype)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor (sole writer of everything below)
    pq_t got;
    int  got_cyc[$];
    int  n_crc = 0, n_trunc = 0, n_wc = 0, n_dtype = 0, n_lvo = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (dvo) begin
                got.push_back(dato);
                got_cyc.push_back(cyc);
            end
            if (lvo)       n_lvo++;
            if (err_crc)   n_crc++;
            if (err_trunc) n_trunc++;
            if (err_wc)    n_wc++;
            if (err_dtype) n_dtype++;
        end
    end

    int total = 0, bad = 0;
    int last_cyc, pay_last_cyc;
    int b_got, b_crc, b_trunc, b_wc, b_dtype, b_lvo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        phy_we  = 1'b0;
        phy_dvo = 1'b0;
        repeat (n) tick();
    endtask

    task automatic put(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 1)) begin
                phy_we  = 1'b1;
                phy_dvo = 1'b0;
                tick();
            end
        end
        phy_we   = 1'b1;
        phy_dvo  = 1'b1;
        phy_data = b;
        last_cyc = cyc;
        tick();
        phy_dvo  = 1'b0;
    endtask

    task automatic send_short(input logic [1:0] vc, input logic [5:0] dt);
        put({vc, dt}, 0);
        put(8'h00, 0);
        put(8'h00, 0);
        put(8'h00, 0);
        idle(2);
    endtask

    // stop_at >= 0 drops phy_we before payload byte stop_at
    task automatic send_long(input logic [1:0] vc, input logic [5:0] dt, input bq_t pl,
                             input logic [15:0] crc, input bit gaps, input int stop_at);
        int n;
        n = pl.size();
        put({vc, dt}, gaps);
        put(8'(n), gaps);
        put(8'(n >> 8), gaps);
        put(8'h00, gaps);
        for (int i = 0; i < n; i++) begin
            if (i == stop_at) begin
                idle(3);
                return;
            end
            put(pl[i], gaps);
            if (i == n - 1) pay_last_cyc = last_cyc;
        end
        put(crc[7:0], gaps);
        put(crc[15:8], gaps);
        idle(2);
    endtask

    function automatic logic [15:0] crc_model(input bq_t pl);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (pl[k]) begin
            for (int j = 0; j < 8; j++) begin
                if ((c[0] ^ pl[k][j]) == 1'b1) c = (c >> 1) ^ 16'h8408;
                else                           c = c >> 1;
            end
        end
        return c;
    endfunction

    function automatic logic [PW-1:0] align(input int v, input int w);
        if (w <= PW) return PW'(v << (PW - w));
        else         return PW'(v >> (w - PW));
    endfunction

    task automatic model_px(input logic [5:0] dt, input bq_t pl, output pq_t px);
        int n;
        px = {};
        n  = pl.size();
        if (dt == 6'h2A) begin
            for (int k = 0; k < n; k++) px.push_back(align(int'(pl[k]), 8));
        end else if (dt == 6'h2B) begin
            for (int g = 0; g + 5 <= n; g += 5)
                for (int i = 0; i < 4; i++)
                    px.push_back(align(int'(pl[g+i]) * 4 + ((int'(pl[g+4]) >> (2*i)) % 4), 10));
        end else begin
            for (int g = 0; g + 3 <= n; g += 3) begin
                px.push_back(align(int'(pl[g]) * 16 + int'(pl[g+2]) % 16, 12));
                px.push_back(align(int'(pl[g+1]) * 16 + int'(pl[g+2]) / 16, 12));
            end
        end
    endtask

    task automatic snap();
        b_got = got.size(); b_crc = n_crc; b_trunc = n_trunc;
        b_wc = n_wc; b_dtype = n_dtype; b_lvo = n_lvo;
    endtask

    task automatic check_pixels(input string tag, input pq_t exp);
        chk({tag, ".count"}, 32'(got.size() - b_got), 32'(exp.size()));
        foreach (exp[i])
            if (b_got + i < got.size())
                chk({tag, ".px"}, 32'(got[b_got + i]), 32'(exp[i]));
    endtask

    task automatic rand_payload(input int n, output bq_t pl);
        pl = {};
        for (int k = 0; k < n; k++) pl.push_back(8'($urandom));
    endtask

    initial begin
        bq_t         pl;
        pq_t         exp;
        logic [5:0]  dt;
        logic [7:0]  ex [24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                                 8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                                 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
        int          r;

        reset = 1'b1; enable = 1'b1; phy_we = 1'b0; phy_dvo = 1'b0; phy_data = '0;
        vc_filter_en = 1'b0; vc_select = 2'd0;
        repeat (3) tick();
        chk("reset.dato", 32'(dato), 0);
        chk("reset.dvo", 32'(dvo), 0);
        chk("reset.lvo", 32'(lvo), 0);
        chk("reset.fvo", 32'(fvo), 0);
        chk("reset.frame_count", 32'(frame_count), 0);
        chk("reset.errs", 32'({err_crc, err_trunc, err_wc, err_dtype}), 0);
        reset = 1'b0;
        idle(2);

        // Frame start, CSI-2 example RAW8 line with its published CRC, frame end
        send_short(2'd0, 6'h00);
        chk("fs.fvo", 32'(fvo), 1);
        snap();
        pl = {};
        foreach (ex[k]) pl.push_back(ex[k]);
        send_long(2'd0, 6'h2A, pl, 16'h00F0, 0, -1);
        idle(20);
        model_px(6'h2A, pl, exp);
        check_pixels("raw8_example", exp);
        chk("raw8_example.err_crc", 32'(n_crc - b_crc), 0);
        chk("raw8_example.lvo_cycles", 32'(n_lvo - b_lvo), 24);
        chk("raw8_example.fvo_held", 32'(fvo), 1);
        send_short(2'd0, 6'h01);
        chk("fe.frame_count", 32'(frame_count), 1);
        chk("fe.fvo", 32'(fvo), 0);

        // RAW10 single group with latency
        snap();
        pl = {8'h12, 8'h34, 8'h56, 8'h78, 8'hE4};
        send_long(2'd0, 6'h2B, pl, crc_model(pl), 0, -1);
        idle(10);
        exp = {PW'(10'h048) << 2, PW'(10'h0D1) << 2, PW'(10'h15A) << 2, PW'(10'h1E3) << 2};
        check_pixels("raw10", exp);
        if (got.size() >= b_got + 4) begin
            chk("raw10.latency", 32'(got_cyc[b_got] - pay_last_cyc), 2);
            chk("raw10.back_to_back", 32'(got_cyc[b_got + 3] - got_cyc[b_got]), 3);
        end

        // RAW12 single group
        snap();
        pl = {8'hAB, 8'hCD, 8'h5A};
        send_long(2'd0, 6'h2C, pl, crc_model(pl), 0, -1);
        idle(10);
        exp = {12'hABA, 12'hCD5};
        check_pixels("raw12", exp);

        // Randomized well-formed packets with random byte gaps
        for (int p = 0; p < 8; p++) begin
            r  = $urandom_range(0, 2);
            dt = (r == 0) ? 6'h2A : (r == 1) ? 6'h2B : 6'h2C;
            snap();
            rand_payload(((r == 0) ? 1 : (r == 1) ? 5 : 3) * $urandom_range(1, 6), pl);
            send_long(2'(p), dt, pl, crc_model(pl), 1, -1);
            idle(15);
            model_px(dt, pl, exp);
            check_pixels("random", exp);
            chk("random.errs", 32'((n_crc - b_crc) + (n_wc - b_wc) + (n_trunc - b_trunc)), 0);
        end

        // Corrupted CRC: one pulse, pixels still delivered
        snap();
        rand_payload(12, pl);
        send_long(2'd0, 6'h2A, pl, crc_model(pl) ^ 16'h0100, 0, -1);
        idle(15);
        model_px(6'h2A, pl, exp);
        check_pixels("crc_bad", exp);
        chk("crc_bad.err_crc", 32'(n_crc - b_crc), 1);

        // Truncation after 10 of 24 bytes
        snap();
        rand_payload(24, pl);
        send_long(2'd0, 6'h2A, pl, crc_model(pl), 0, 10);
        idle(15);
        model_px(6'h2A, pl[0:9], exp);
        check_pixels("trunc", exp);
        chk("trunc.err_trunc", 32'(n_trunc - b_trunc), 1);
        chk("trunc.err_crc", 32'(n_crc - b_crc), 0);
        chk("trunc.lvo", 32'(lvo), 0);

        // RAW10 with WC=7: one group, trailing bytes dropped
        snap();
        rand_payload(7, pl);
        send_long(2'd0, 6'h2B, pl, crc_model(pl), 0, -1);
        idle(15);
        model_px(6'h2B, pl, exp);
        check_pixels("raw10_wc7", exp);
        chk("raw10_wc7.err_wc", 32'(n_wc - b_wc), 1);
        chk("raw10_wc7.err_crc", 32'(n_crc - b_crc), 0);

        // VC filter
        vc_filter_en = 1'b1;
        vc_select    = 2'd1;
        snap();
        send_short(2'd0, 6'h00);
        chk("vcf.fs_ignored", 32'(fvo), 0);
        rand_payload(6, pl);
        send_long(2'd0, 6'h2A, pl, crc_model(pl), 0, -1);
        idle(10);
        chk("vcf.no_pixels", 32'(got.size() - b_got), 0);
        chk("vcf.no_lvo", 32'(n_lvo - b_lvo), 0);
        send_long(2'd1, 6'h2A, pl, crc_model(pl), 0, -1);
        idle(10);
        model_px(6'h2A, pl, exp);
        check_pixels("vcf.accepted", exp);
        vc_filter_en = 1'b0;

        // Unsupported long-packet data type
        snap();
        rand_payload(6, pl);
        send_long(2'd0, 6'h30, pl, crc_model(pl), 0, -1);
        idle(10);
        chk("dtype.err_dtype", 32'(n_dtype - b_dtype), 1);
        chk("dtype.no_pixels", 32'(got.size() - b_got), 0);

        // Enable dropped mid-payload, then a clean packet
        send_short(2'd0, 6'h00);
        rand_payload(16, pl);
        put({2'd0, 6'h2A}, 0); put(8'd16, 0); put(8'd0, 0); put(8'h00, 0);
        for (int k = 0; k < 8; k++) put(pl[k], 0);
        enable = 1'b0;
        tick();
        chk("enable.outs", 32'({dvo, lvo, fvo}), 0);
        chk("enable.dato", 32'(dato), 0);
        chk("enable.frame_count", 32'(frame_count), 1);
        idle(4);
        enable = 1'b1;
        idle(2);
        snap();
        rand_payload(9, pl);
        send_long(2'd0, 6'h2C, pl, crc_model(pl), 1, -1);
        idle(15);
        model_px(6'h2C, pl, exp);
        check_pixels("reenable", exp);

        // Reset mid-packet
        send_short(2'd0, 6'h00);
        rand_payload(10, pl);
        put({2'd0, 6'h2A}, 0); put(8'd10, 0); put(8'd0, 0); put(8'h00, 0);
        for (int k = 0; k < 4; k++) put(pl[k], 0);
        reset = 1'b1;
        tick();
        chk("midreset.outs", 32'({dvo, lvo, fvo}), 0);
        chk("midreset.dato", 32'(dato), 0);
        chk("midreset.frame_count", 32'(frame_count), 0);
        chk("midreset.errs", 32'({err_crc, err_trunc, err_wc, err_dtype}), 0);
        reset = 1'b0;
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
